bht_update_scheduler: RTL and testbench
=======================================

# bht_update_scheduler

Sequences all writes into the branch history table (BHT) of the branch prediction unit. It owns the table's single write port and shares it between three requesters:

- the post-reset clearing sweep;
- software-requested invalidate-all sweeps;
- branch-resolution updates arriving from EXE, buffered in a small coalescing FIFO.

It also reports when table contents are trustworthy, so that the predictor can treat lookups as misses during a sweep.

## Interface
Parameters:
- DEPTH, 4 — update FIFO entries (power of two, ≥2)
- INDEX_W, 7 — BHT index width; table has 2^INDEX_W entries; index = PC[INDEX_W+1:2], tag = PC[31:INDEX_W+2]

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- upd_valid  in  1  EXE presents a resolved-branch update this cycle
- upd_pc  in  32  branch PC
- upd_target  in  32  resolved target
- upd_type  in  2  branch type (00 none, 01 imme, 10 call, 11 retn)
- upd_count  in  2  new saturating-counter value (00 NT, 01 WNT, 10 WT, 11 T)
- upd_ready  out  1  update accepted when upd_valid && upd_ready
- inv_req  in  1  single-cycle pulse: invalidate the whole table
- wr_en  out  1  BHT write strobe
- wr_index  out  INDEX_W  BHT write address
- wr_tag  out  30-INDEX_W  tag field written
- wr_target  out  32  target field written
- wr_type  out  2  type field written
- wr_count  out  2  counter field written
- bht_valid  out  1  high only in state IDLE; predictor forces a miss when low
- pending  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
States: INIT, IDLE, SWEEP. Reset enters INIT with sweep_idx=0, FIFO empty.

INIT / SWEEP:
- Each cycle: wr_en=1, wr_index=sweep_idx, clear entry (tag 0, target 0, type 00, count 01), sweep_idx+1.
- Last index is 2^INDEX_W-1, then go to IDLE.
- inv_req during INIT or SWEEP restarts sweep_idx at 0.
- FIFO is not drained; updates are still accepted while not full.

IDLE:
- inv_req → SWEEP with sweep_idx=0 at the next edge; the write in the inv_req cycle proceeds normally.
- Otherwise, if the FIFO is non-empty, write the head entry and pop it.
- If the FIFO is empty and an update is accepted this cycle, bypass: write the update combinationally in the same cycle; it does not enter the FIFO.

Push:
- Accepted update is pushed unless bypassed.
- Coalescing: if the FIFO is non-empty and upd_pc[INDEX_W+1:2] equals the index of the newest entry (and that entry is not being popped this cycle), overwrite the newest entry in place; occupancy is unchanged.
- Push and pop in the same cycle are allowed.

Ready and outputs:
- upd_ready = (pending < DEPTH); depends on registered state only.
- Write-port priority: sweep > FIFO head > bypass.
- wr_* are don't-care when wr_en=0.
- While rst=1: wr_en=0, upd_ready=0, bht_valid=0.

## Timing
- Reset values: state INIT, pending 0, bht_valid 0, upd_ready 1, wr_en 1 with wr_index 0 in the first cycle after rst deasserts.
- Post-reset sweep lasts 2^INDEX_W cycles; bht_valid rises in cycle 2^INDEX_W after reset release (128 with defaults).
- Bypass latency is 0 cycles. Queued latency is the number of entries ahead plus 1.
- An entry pushed in cycle N is never written before cycle N+1.
- The pending count updates at the edge after push/pop.
- FIFO pointers wrap modulo DEPTH.
- Full FIFO: upd_ready=0; EXE holds upd_valid and its data stable until accepted.
- rst mid-sweep or with a full FIFO discards all queued updates and restarts INIT at index 0.

## Test plan
- Reset release: wr_en=1 with wr_index 0,1,…,127 on consecutive cycles, every write carrying count 01; bht_valid=1 from cycle 128; pending=0 throughout.
- Bypass in IDLE with an empty FIFO: upd_pc=0x0000_0104, upd_count=11 → same-cycle wr_index=0x41, wr_tag=0, wr_count=11; pending stays 0.
- Updates queued behind a sweep:
  - inv_req, then 5 updates with distinct indices on consecutive cycles.
  - Expect 4 accepted and upd_ready=0 while pending=4.
  - After 128 sweep cycles, the queued entries are written in order on consecutive cycles.
  - The 5th update is accepted the cycle after the first pop.
- Coalescing: during a sweep, push PC 0x200 with count 01, then PC 0x200 with count 10 → pending=1; after the sweep, a single write to index 0x00 with count 10.
- inv_req at sweep_idx=60 → next wr_index=0; bht_valid stays 0 for a further 128 cycles.
- rst asserted with pending=3 → pending=0 and wr_en=0 while rst=1; after release, the INIT sweep restarts at index 0 and no stale update is ever written.

Source files
------------

// File: rtl/bht_update_scheduler.sv
// bht_update_scheduler: owns the BHT write port and arbitrates between the
// clearing sweeps (post-reset and invalidate-all) and EXE branch updates.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   upd_valid/ready  EXE update handshake; upd_pc/target/type/count payload
//   inv_req          single-cycle pulse, invalidate the whole table
//   wr_en, wr_*      BHT write strobe, address and entry fields
//   bht_valid        table contents trustworthy (IDLE only)
//   pending          update FIFO occupancy
module bht_update_scheduler #(
    parameter int DEPTH   = 4,
    parameter int INDEX_W = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     upd_valid,
    input  logic [31:0]              upd_pc,
    input  logic [31:0]              upd_target,
    input  logic [1:0]               upd_type,
    input  logic [1:0]               upd_count,
    output logic                     upd_ready,
    input  logic                     inv_req,
    output logic                     wr_en,
    output logic [INDEX_W-1:0]       wr_index,
    output logic [29-INDEX_W:0]      wr_tag,
    output logic [31:0]              wr_target,
    output logic [1:0]               wr_type,
    output logic [1:0]               wr_count,
    output logic                     bht_valid,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = 30 - INDEX_W;
    localparam logic [INDEX_W-1:0] LAST = '1;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_SWEEP
    } state_t;

    typedef struct packed {
        logic [INDEX_W-1:0] idx;
        logic [TW-1:0]      tag;
        logic [31:0]        target;
        logic [1:0]         btype;
        logic [1:0]         count;
    } entry_t;

    state_t             state;
    state_t             state_nx;
    logic [INDEX_W-1:0] sweep_idx;
    logic [INDEX_W-1:0] sweep_nx;

    entry_t             mem [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      new_ptr;
    logic [CW-1:0]      cnt;

    entry_t             upd_e;
    entry_t             wr_e;
    logic               sweeping;
    logic               fifo_empty;
    logic               accept;
    logic               pop;
    logic               bypass;
    logic               coal;
    logic               push;
    logic               unused;

    // Byte offset bits of the PC never reach the table.
    assign unused = ^upd_pc[1:0];

    assign upd_e.idx    = upd_pc[INDEX_W+1:2];
    assign upd_e.tag    = upd_pc[31:INDEX_W+2];
    assign upd_e.target = upd_target;
    assign upd_e.btype  = upd_type;
    assign upd_e.count  = upd_count;

    assign sweeping   = (state != S_IDLE);
    assign fifo_empty = (cnt == '0);
    assign new_ptr    = wr_ptr - 1'b1;

    // Ready looks only at registered occupancy, never at upd_valid.
    assign upd_ready = !rst && (cnt < CW'(DEPTH));
    assign accept    = upd_valid && upd_ready;

    assign pop    = !rst && !sweeping && !fifo_empty;
    assign bypass = accept && !sweeping && fifo_empty;

    // Merge into the newest entry unless it is leaving this cycle.
    assign coal = accept && !fifo_empty
               && (upd_e.idx == mem[new_ptr].idx)
               && !(pop && cnt == CW'(1));

    assign push = accept && !bypass && !coal;

    assign bht_valid = !rst && (state == S_IDLE);
    assign pending   = rst ? '0 : cnt;

    // Write-port arbitration: sweep, then FIFO head, then bypass.
    always_comb begin
        wr_en = 1'b0;
        wr_e  = upd_e;
        if (rst) begin
            wr_en = 1'b0;
        end else if (sweeping) begin
            wr_en        = 1'b1;
            wr_e.idx     = sweep_idx;
            wr_e.tag     = '0;
            wr_e.target  = '0;
            wr_e.btype   = 2'b00;
            wr_e.count   = 2'b01;
        end else if (!fifo_empty) begin
            wr_en = 1'b1;
            wr_e  = mem[rd_ptr];
        end else if (bypass) begin
            wr_en = 1'b1;
            wr_e  = upd_e;
        end
    end

    assign wr_index  = wr_e.idx;
    assign wr_tag    = wr_e.tag;
    assign wr_target = wr_e.target;
    assign wr_type   = wr_e.btype;
    assign wr_count  = wr_e.count;

    always_comb begin
        state_nx = state;
        sweep_nx = sweep_idx;
        unique case (state)
            S_INIT, S_SWEEP: begin
                if (inv_req) begin
                    sweep_nx = '0;
                end else if (sweep_idx == LAST) begin
                    state_nx = S_IDLE;
                    sweep_nx = '0;
                end else begin
                    sweep_nx = sweep_idx + 1'b1;
                end
            end
            S_IDLE: begin
                if (inv_req) begin
                    state_nx = S_SWEEP;
                    sweep_nx = '0;
                end
            end
            default: begin
                state_nx = S_INIT;
                sweep_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            sweep_idx <= '0;
        end else begin
            state     <= state_nx;
            sweep_idx <= sweep_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= upd_e;
        end else if (coal) begin
            mem[new_ptr] <= upd_e;
        end
    end

endmodule

// File: tb/tb_bht_update_scheduler.sv
// tb_bht_update_scheduler: scoreboard bench for bht_update_scheduler,
// driven by directed phases and random traffic against a queue model.
module tb_bht_update_scheduler;

    localparam int DEPTH   = 4;
    localparam int INDEX_W = 7;
    localparam int NIDX    = 1 << INDEX_W;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic [1:0]  btype;
        logic [1:0]  count;
    } upd_t;

    logic        clk;
    logic        rst;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic [1:0]  upd_type;
    logic [1:0]  upd_count;
    logic        upd_ready;
    logic        inv_req;
    logic        wr_en;
    logic [6:0]  wr_index;
    logic [22:0] wr_tag;
    logic [31:0] wr_target;
    logic [1:0]  wr_type;
    logic [1:0]  wr_count;
    logic        bht_valid;
    logic [2:0]  pending;

    bht_update_scheduler #(
        .DEPTH(DEPTH),
        .INDEX_W(INDEX_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .upd_valid(upd_valid),
        .upd_pc(upd_pc),
        .upd_target(upd_target),
        .upd_type(upd_type),
        .upd_count(upd_count),
        .upd_ready(upd_ready),
        .inv_req(inv_req),
        .wr_en(wr_en),
        .wr_index(wr_index),
        .wr_tag(wr_tag),
        .wr_target(wr_target),
        .wr_type(wr_type),
        .wr_count(wr_count),
        .bht_valid(bht_valid),
        .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors;
    int          miscompares;
    logic [65:0] exp_q [$];

    // Reference model: sweep position plus a plain queue of updates.
    bit          m_idle;
    int          m_pos;
    upd_t        m_fifo [$];

    function automatic logic [65:0] pack(logic [31:0] pc,
                                         logic [31:0] tgt,
                                         logic [1:0] ty,
                                         logic [1:0] ct);
        return {pc[8:2], pc[31:9], tgt, ty, ct};
    endfunction

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step(bit r, bit inv, bit v, upd_t u,
                        output bit acc);
        bit          e_ready;
        bit          e_bv;
        int          e_pend;
        bit          byp;
        upd_t        h;
        @(posedge clk);
        #1;
        rst        = r;
        inv_req    = inv;
        upd_valid  = v;
        upd_pc     = u.pc;
        upd_target = u.target;
        upd_type   = u.btype;
        upd_count  = u.count;
        acc = 0;
        byp = 0;
        if (r) begin
            e_ready = 0;
            e_bv    = 0;
            e_pend  = 0;
            m_fifo.delete();
            m_idle = 0;
            m_pos  = 0;
        end else begin
            e_ready = m_fifo.size() < DEPTH;
            e_bv    = m_idle;
            e_pend  = m_fifo.size();
            acc     = v && e_ready;
            if (!m_idle) begin
                exp_q.push_back(pack(m_pos << 2, 0, 2'b00, 2'b01));
            end else if (m_fifo.size() > 0) begin
                h = m_fifo.pop_front();
                exp_q.push_back(pack(h.pc, h.target, h.btype, h.count));
            end else if (acc) begin
                exp_q.push_back(pack(u.pc, u.target, u.btype, u.count));
                byp = 1;
            end
            if (acc && !byp) begin
                if (m_fifo.size() > 0 &&
                    m_fifo[m_fifo.size()-1].pc[8:2] == u.pc[8:2])
                    m_fifo[m_fifo.size()-1] = u;
                else
                    m_fifo.push_back(u);
            end
            if (inv) begin
                m_idle = 0;
                m_pos  = 0;
            end else if (!m_idle) begin
                if (m_pos == NIDX - 1) m_idle = 1;
                else m_pos++;
            end
        end
        #1;
        check("upd_ready", 32'(upd_ready), 32'(e_ready));
        check("pending", 32'(pending), 32'(e_pend));
        check("bht_valid", 32'(bht_valid), 32'(e_bv));
    endtask

    upd_t nil;

    task automatic idle(int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, 0, 0, nil, a);
    endtask

    task automatic send(upd_t u);
        bit a;
        int n;
        a = 0;
        n = 0;
        while (!a && n < 400) begin
            step(0, 0, 1, u, a);
            n++;
        end
        if (!a) begin
            miscompares++;
            $display("FAIL send_timeout: pc %0h never accepted", u.pc);
        end
    endtask

    function automatic upd_t mk(logic [31:0] pc, logic [1:0] ct);
        upd_t u;
        u.pc     = pc;
        u.target = $urandom;
        u.btype  = 2'($urandom);
        u.count  = ct;
        return u;
    endfunction

    task automatic monitor();
        logic [65:0] got;
        logic [65:0] e;
        forever begin
            @(negedge clk);
            if (wr_en === 1'b1) begin
                vectors++;
                got = {wr_index, wr_tag, wr_target, wr_type, wr_count};
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL write_unexpected: got %h expected none",
                             got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        miscompares++;
                        $display("FAIL write: got %h expected %h at %0t",
                                 got, e, $time);
                    end
                end
            end
        end
    endtask

    initial begin
        bit   a;
        bit   have;
        upd_t req;
        vectors     = 0;
        miscompares = 0;
        rst         = 1;
        inv_req     = 0;
        upd_valid   = 0;
        upd_pc      = 0;
        upd_target  = 0;
        upd_type    = 0;
        upd_count   = 0;
        nil         = '{default: '0};
        m_idle      = 0;
        m_pos       = 0;
        fork
            monitor();
        join_none

        // Reset and the full post-reset sweep.
        for (int i = 0; i < 3; i++) step(1, 0, 0, nil, a);
        idle(NIDX + 2);

        // Same-cycle bypass into an idle table.
        send(mk(32'h0000_0104, 2'b11));
        idle(2);

        // Five updates queued behind an invalidate sweep.
        step(0, 1, 0, nil, a);
        for (int i = 1; i <= 5; i++) send(mk(32'(i * 16), 2'(i)));
        idle(10);

        // Two updates to one index merge into a single write.
        step(0, 1, 0, nil, a);
        send(mk(32'h0000_0200, 2'b01));
        send(mk(32'h0000_0200, 2'b10));
        idle(NIDX + 4);

        // Invalidate restarting a sweep partway through.
        step(0, 1, 0, nil, a);
        idle(60);
        step(0, 1, 0, nil, a);
        idle(NIDX + 4);

        // Reset with three queued updates throws them away.
        step(0, 1, 0, nil, a);
        send(mk(32'h0000_0010, 2'b11));
        send(mk(32'h0000_0020, 2'b11));
        send(mk(32'h0000_0030, 2'b11));
        step(1, 0, 0, nil, a);
        step(1, 0, 0, nil, a);
        idle(NIDX + 4);

        // Random traffic on a small index set to provoke merging.
        have = 0;
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit inv;
            r   = ($urandom_range(0, 499) == 0);
            inv = ($urandom_range(0, 199) == 0);
            if (!have && $urandom_range(0, 1) == 1) begin
                req = mk($urandom, 2'($urandom));
                req.pc[8:2] = 7'($urandom_range(0, 5));
                have = 1;
            end
            step(r, inv, have && !r, req, a);
            if (a || r) have = 0;
        end
        idle(NIDX + DEPTH + 4);
        step(0, 0, 0, nil, a);
        check("leftover_writes", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
